arm_main_fsm: RTL and testbench
===============================

// Module: arm_main_fsm
// PURPOSE
// Multicycle ARM main controller FSM. It sequences each instruction through
// fetch, decode, execute, memory and writeback states.
// Upstream: Op/Funct from the instruction register. Downstream: ALUOp to the
// ALU decoder, plus datapath mux selects and write enables.
// It is the ALUOp/Funct initiator for the ALU decoder. Cond-logic gating of
// RegW/MemW/NextPC/Branch happens downstream.
// PARAMETERS
// UNDEF_TRAP  0  0: Op=2'b11 returns to FETCH; 1: Op=2'b11 enters HALT until rst
// PORTS
// clk         in   1  clock, all state updates on posedge
// rst         in   1  synchronous, active-high reset
// Op          in   2  instr[27:26]: 00 data-proc, 01 mem, 10 branch, 11 undef
// Funct       in   6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S/L
// IRWrite     out  1  load instruction register
// AdrSrc      out  1  0: mem addr=PC, 1: mem addr=Result
// ALUSrcA     out  1  0: RD1, 1: PC
// ALUSrcB     out  2  00 RD2, 01 ExtImm, 10 const 4
// ResultSrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
// ALUOp       out  1  1: ALU decoder uses Funct; 0: forced ADD
// NextPC      out  1  PC write request
// RegW        out  1  register-file write request (pre-cond)
// MemW        out  1  memory write request (pre-cond)
// Branch      out  1  branch request (pre-cond)
// InstrDone   out  1  1-cycle pulse in the last state of each instruction
// State       out  4  current state encoding (debug)
// BEHAVIOUR
// - Moore machine: every output is a decode of the registered state only.
//   Outputs not listed for a state are 0.
// - Encodings: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECR=6
//   EXECI=7 ALUWB=8 BRANCH=9 HALT=15. Any other code -> FETCH.
// - rst=1 at a posedge -> State=FETCH next cycle, including mid-instruction.
//   rst has priority over every transition.
// - FETCH: IRWrite=1 AdrSrc=0 ALUSrcA=1 ALUSrcB=10 ResultSrc=10 NextPC=1.
//   -> DECODE.
// - DECODE: ALUSrcA=1 ALUSrcB=10 ResultSrc=10. Op and Funct are sampled here:
//   Op=01 -> MEMADR; Op=00&I=0 -> EXECR; Op=00&I=1 -> EXECI; Op=10 -> BRANCH;
//   Op=11 -> HALT if UNDEF_TRAP else FETCH. When Op=11 returns to FETCH,
//   InstrDone=1 in DECODE.
// - MEMADR: ALUSrcA=0 ALUSrcB=01. -> MEMRD if Funct[0]=1 (LDR), else MEMWR.
//   Funct[0] is resampled here.
// - MEMRD: AdrSrc=1 ResultSrc=00 -> MEMWB.
// - MEMWB: ResultSrc=01 RegW=1 InstrDone=1 -> FETCH.
// - MEMWR: AdrSrc=1 ResultSrc=00 MemW=1 InstrDone=1 -> FETCH.
// - EXECR: ALUSrcA=0 ALUSrcB=00 ALUOp=1 -> ALUWB.
// - EXECI: ALUSrcA=0 ALUSrcB=01 ALUOp=1 -> ALUWB.
// - ALUWB: ResultSrc=00 RegW=1 InstrDone=1 -> FETCH. RegW is asserted even
//   for CMP; NoWrite suppression is downstream.
// - BRANCH: ALUSrcA=0 ALUSrcB=01 ResultSrc=10 Branch=1 InstrDone=1 -> FETCH.
// - HALT: all outputs 0, self-loop; only rst exits.
// - Latency in cycles: LDR 5, STR 4, data-proc 4, branch 3, undef 2.
// - Op/Funct changing outside DECODE/MEMADR have no effect.
// TESTING
// - rst=1 for 3 cycles, release -> State=0, IRWrite=1, NextPC=1, ALUOp=0.
// - Op=00 Funct=6'b001000 (ADD reg) -> states 0,1,6,8; ALUOp=1 only in
//   state 6; RegW+InstrDone in state 8.
// - Op=01 Funct=6'b011001 (LDR) -> states 0,1,2,3,4. Repeat with
//   Funct[0]=0 (STR) -> states 0,1,2,5 with MemW=1 only in state 5.
// - Op=10 -> states 0,1,9; Branch=1, ALUSrcB=01, ResultSrc=10 in state 9;
//   Op=00 Funct=6'b101000 -> state 7 with ALUSrcB=01.
// - Op=11: UNDEF_TRAP=0 -> State 0,1,0 with InstrDone=1 in state 1;
//   UNDEF_TRAP=1 -> State=15 held 10 cycles with outputs 0 until rst.
// - Assert rst in state 3 (mid-LDR) -> State=0 next cycle, no RegW pulse
//   ever seen; random Op/Funct stream -> every instr ends with one InstrDone.

Source files
------------

// File: rtl/arm_main_fsm.sv
// arm_main_fsm: multicycle ARM main controller.
// Sequences each instruction through fetch, decode, execute, memory and
// writeback states. It drives ALUOp to the ALU decoder plus the datapath mux
// selects and the pre-condition write requests. Condition gating of
// RegW/MemW/NextPC/Branch is applied downstream.
// The outputs are a decode of the registered state. The one exception is
// InstrDone in DECODE, which also looks at Op so that an undefined
// instruction can retire in that state.
module arm_main_fsm #(
    parameter logic UNDEF_TRAP = 1'b0   // 1: undefined op parks the FSM in HALT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       InstrDone,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_HALT   = 4'd15
    } state_e;

    state_e state_q;
    state_e state_d;

    // The ALU command bits are consumed by the ALU decoder, not by this FSM.
    logic funct_unused;
    assign funct_unused = ^Funct[4:1];

    // State register; synchronous reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Op/Funct only matter in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00: begin
                        if (Funct[5]) begin
                            state_d = S_EXECI;
                        end else begin
                            state_d = S_EXECR;
                        end
                    end
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: begin
                        if (UNDEF_TRAP) begin
                            state_d = S_HALT;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                if (Funct[0]) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode of the current state; anything not set here stays 0.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        InstrDone = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                NextPC    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // An undefined op that returns to FETCH retires right here.
                InstrDone = (Op == 2'b11) && (UNDEF_TRAP == 1'b0);
            end
            S_MEMADR: begin
                ALUSrcB   = 2'b01;
            end
            S_MEMRD: begin
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
                InstrDone = 1'b1;
            end
            S_EXECR: begin
                ALUOp     = 1'b1;
            end
            S_EXECI: begin
                ALUSrcB   = 2'b01;
                ALUOp     = 1'b1;
            end
            S_ALUWB: begin
                // Written even for compares; NoWrite is filtered downstream.
                RegW      = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
                InstrDone = 1'b1;
            end
            S_HALT: begin
                IRWrite   = 1'b0;
            end
            default: begin
                IRWrite   = 1'b0;
            end
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_arm_main_fsm.sv
// Scoreboard bench for arm_main_fsm. Two instances share clock and Op/Funct:
// "m" with UNDEF_TRAP=0 and "t" with UNDEF_TRAP=1 (held in reset until the
// trap phase). Stimulus pushes the expected state of both instances for
// every cycle; a negedge monitor pops and compares state and all outputs.
module tb_arm_main_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst_t;
    logic [1:0] Op;
    logic [5:0] Funct;

    logic m_IRWrite, m_AdrSrc, m_ALUSrcA, m_ALUOp, m_NextPC, m_RegW, m_MemW, m_Branch, m_InstrDone;
    logic [1:0] m_ALUSrcB, m_ResultSrc;
    logic [3:0] m_State;
    logic t_IRWrite, t_AdrSrc, t_ALUSrcA, t_ALUOp, t_NextPC, t_RegW, t_MemW, t_Branch, t_InstrDone;
    logic [1:0] t_ALUSrcB, t_ResultSrc;
    logic [3:0] t_State;

    arm_main_fsm #(.UNDEF_TRAP(1'b0)) u_m (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct),
        .IRWrite(m_IRWrite), .AdrSrc(m_AdrSrc), .ALUSrcA(m_ALUSrcA), .ALUSrcB(m_ALUSrcB),
        .ResultSrc(m_ResultSrc), .ALUOp(m_ALUOp), .NextPC(m_NextPC), .RegW(m_RegW),
        .MemW(m_MemW), .Branch(m_Branch), .InstrDone(m_InstrDone), .State(m_State)
    );

    arm_main_fsm #(.UNDEF_TRAP(1'b1)) u_t (
        .clk(clk), .rst(rst_t), .Op(Op), .Funct(Funct),
        .IRWrite(t_IRWrite), .AdrSrc(t_AdrSrc), .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB),
        .ResultSrc(t_ResultSrc), .ALUOp(t_ALUOp), .NextPC(t_NextPC), .RegW(t_RegW),
        .MemW(t_MemW), .Branch(t_Branch), .InstrDone(t_InstrDone), .State(t_State)
    );

    // Output vector order: IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc ALUOp NextPC RegW MemW Branch InstrDone
    logic [12:0] m_vec, t_vec;
    assign m_vec = {m_IRWrite, m_AdrSrc, m_ALUSrcA, m_ALUSrcB, m_ResultSrc, m_ALUOp,
                    m_NextPC, m_RegW, m_MemW, m_Branch, m_InstrDone};
    assign t_vec = {t_IRWrite, t_AdrSrc, t_ALUSrcA, t_ALUSrcB, t_ResultSrc, t_ALUOp,
                    t_NextPC, t_RegW, t_MemW, t_Branch, t_InstrDone};

    // Hand-written output table per state (InstrDone in DECODE added separately).
    function automatic logic [12:0] exp_outs(input logic [3:0] s);
        case (s)
            4'd0:    exp_outs = 13'b1_0_1_10_10_0_1_0_0_0_0;
            4'd1:    exp_outs = 13'b0_0_1_10_10_0_0_0_0_0_0;
            4'd2:    exp_outs = 13'b0_0_0_01_00_0_0_0_0_0_0;
            4'd3:    exp_outs = 13'b0_1_0_00_00_0_0_0_0_0_0;
            4'd4:    exp_outs = 13'b0_0_0_00_01_0_0_1_0_0_1;
            4'd5:    exp_outs = 13'b0_1_0_00_00_0_0_0_1_0_1;
            4'd6:    exp_outs = 13'b0_0_0_00_00_1_0_0_0_0_0;
            4'd7:    exp_outs = 13'b0_0_0_01_00_1_0_0_0_0_0;
            4'd8:    exp_outs = 13'b0_0_0_00_00_0_0_1_0_0_1;
            4'd9:    exp_outs = 13'b0_0_0_01_10_0_0_0_0_1_1;
            default: exp_outs = 13'b0_0_0_00_00_0_0_0_0_0_0;
        endcase
    endfunction

    typedef struct {
        logic [3:0] em;   // expected main state
        logic [3:0] et;   // expected trap-instance state
        logic       dm;   // main InstrDone expected in DECODE (undef op)
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_instr = 0;
    int cyc     = 0;

    // Monitor: count retire pulses and compare against the scoreboard.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_InstrDone === 1'b1) n_done = n_done + 1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_tests = n_tests + 4;
            if (m_State !== mon_e.em) begin
                n_fail = n_fail + 1;
                $display("FAIL m_state cyc=%0d got %0d exp %0d", cyc, m_State, mon_e.em);
            end
            if (m_vec !== (exp_outs(mon_e.em) | {12'd0, mon_e.dm})) begin
                n_fail = n_fail + 1;
                $display("FAIL m_outs cyc=%0d state=%0d got %b exp %b", cyc, mon_e.em, m_vec,
                         exp_outs(mon_e.em) | {12'd0, mon_e.dm});
            end
            if (t_State !== mon_e.et) begin
                n_fail = n_fail + 1;
                $display("FAIL t_state cyc=%0d got %0d exp %0d", cyc, t_State, mon_e.et);
            end
            if (t_vec !== exp_outs(mon_e.et)) begin
                n_fail = n_fail + 1;
                $display("FAIL t_outs cyc=%0d state=%0d got %b exp %b", cyc, mon_e.et, t_vec,
                         exp_outs(mon_e.et));
            end
        end
    end

    // One cycle: record expected states after this edge, set inputs for the next edge.
    task automatic step(input logic [3:0] em, input logic [3:0] et, input logic [1:0] op,
                        input logic [5:0] fn, input logic rm, input logic rt);
        exp_t e;
        @(posedge clk);
        #1;
        e.em = em;
        e.et = et;
        e.dm = (em == 4'd1) && (op == 2'b11);
        q.push_back(e);
        Op    = op;
        Funct = fn;
        rst   = rm;
        rst_t = rt;
    endtask

    // One complete instruction on the main instance; junk inputs outside DECODE/MEMADR.
    task automatic instr(input logic [1:0] op, input logic [5:0] fn);
        logic [3:0] seq[$];
        seq.push_back(4'd0);
        seq.push_back(4'd1);
        case (op)
            2'b00: begin
                seq.push_back(fn[5] ? 4'd7 : 4'd6);
                seq.push_back(4'd8);
            end
            2'b01: begin
                seq.push_back(4'd2);
                if (fn[0]) begin
                    seq.push_back(4'd3);
                    seq.push_back(4'd4);
                end else begin
                    seq.push_back(4'd5);
                end
            end
            2'b10: seq.push_back(4'd9);
            default: ;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == 4'd1 || seq[i] == 4'd2)
                step(seq[i], 4'd0, op, fn, 1'b0, 1'b1);
            else
                step(seq[i], 4'd0, 2'($urandom), 6'($urandom), 1'b0, 1'b1);
        end
        n_instr = n_instr + 1;
    endtask

    initial begin
        logic [1:0] rop;
        logic [5:0] rfn;
        rst   = 1'b1;
        rst_t = 1'b1;
        Op    = 2'b00;
        Funct = 6'b000000;

        // Reset held for three edges (initial value plus two steps).
        step(4'd0, 4'd0, 2'b11, 6'b111111, 1'b1, 1'b1);
        step(4'd0, 4'd0, 2'b10, 6'b000001, 1'b1, 1'b1);

        // Directed instructions.
        instr(2'b00, 6'b001000);   // ADD reg: 0,1,6,8
        instr(2'b01, 6'b011001);   // LDR: 0,1,2,3,4
        instr(2'b01, 6'b011000);   // STR: 0,1,2,5
        instr(2'b10, 6'b000000);   // B: 0,1,9
        instr(2'b00, 6'b101000);   // ADD imm: 0,1,7,8
        instr(2'b11, 6'b000000);   // undef: 0,1 (retires in DECODE)

        // Funct[0] resampled in MEMADR: LDR in DECODE, STR by MEMADR -> MEMWR.
        step(4'd0, 4'd0, 2'b01, 6'b011001, 1'b0, 1'b1);
        step(4'd1, 4'd0, 2'b01, 6'b011001, 1'b0, 1'b1);
        step(4'd2, 4'd0, 2'b01, 6'b011000, 1'b0, 1'b1);
        step(4'd5, 4'd0, 2'b01, 6'b011001, 1'b0, 1'b1);
        n_instr = n_instr + 1;

        // Reset in MEMRD: LDR aborts, no MEMWB, no retire.
        step(4'd0, 4'd0, 2'b01, 6'b011001, 1'b0, 1'b1);
        step(4'd1, 4'd0, 2'b01, 6'b011001, 1'b0, 1'b1);
        step(4'd2, 4'd0, 2'b01, 6'b011001, 1'b0, 1'b1);
        step(4'd3, 4'd0, 2'b01, 6'b011001, 1'b1, 1'b1);

        // Random instruction stream.
        for (int k = 0; k < 12; k++) begin
            rop = 2'($urandom_range(0, 3));
            rfn = 6'($urandom);
            instr(rop, rfn);
        end

        // Trap phase: main held in reset, trap instance runs an undef op.
        step(4'd0, 4'd0, 2'b11, 6'b000000, 1'b1, 1'b0);
        step(4'd0, 4'd1, 2'b11, 6'b000000, 1'b1, 1'b0);
        for (int h = 0; h < 10; h++)
            step(4'd0, 4'd15, 2'($urandom), 6'($urandom), 1'b1, (h == 9) ? 1'b1 : 1'b0);
        step(4'd0, 4'd0, 2'b00, 6'b000000, 1'b1, 1'b1);
        step(4'd0, 4'd0, 2'b00, 6'b000000, 1'b1, 1'b1);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_tests = n_tests + 1;
        if (q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL sb_drain got %0d left exp 0", q.size());
        end
        n_tests = n_tests + 1;
        if (n_done != n_instr) begin
            n_fail = n_fail + 1;
            $display("FAIL instr_done_count got %0d exp %0d", n_done, n_instr);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
